// File: rtl/panel_cmd_arbiter.sv
// Round-robin arbiter between the front panel and the serial host for CPU control commands.
// Define HOST_PRIORITY_EN to make the host win every tie instead of alternating.
module panel_cmd_arbiter #(
    parameter int unsigned HOLDOFF = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_req,
    input  logic [3:0]  p_cmd,
    input  logic [15:0] p_val,
    output logic        p_ack,
    output logic        p_nack,
    input  logic        h_req,
    input  logic [3:0]  h_cmd,
    input  logic [15:0] h_val,
    output logic        h_ack,
    output logic        h_nack,
    input  logic        stopped,
    output logic [11:0] strobe,
    output logic [15:0] user_input,
    output logic        input_valid,
    output logic        busy,
    output logic        last_host
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_cmd;
    logic [15:0] r_val;
    logic        r_last_host;

    logic        w_grant_host;
    logic        w_legal;
    logic        w_needs_stop;
    logic        w_accept;
    logic [11:0] w_onehot;

`ifdef HOST_PRIORITY_EN
    assign w_grant_host = h_req;
`else
    // On a tie the requester that was not served last takes the grant.
    assign w_grant_host = h_req && (!p_req || !r_last_host);
`endif

    assign w_legal      = (r_cmd >= 4'd1) && (r_cmd <= 4'd12);
    assign w_needs_stop = (r_cmd == 4'd4) || (r_cmd == 4'd6);
    assign w_accept     = w_legal && !(w_needs_stop && !stopped);

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < 12; i++) w_onehot[i] = (r_cmd == 4'(i + 1));
    end

    // NOTE: every output of this block gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        strobe      = '0;
        input_valid = 1'b0;
        p_ack       = 1'b0;
        p_nack      = 1'b0;
        h_ack       = 1'b0;
        h_nack      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (p_req || h_req) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_accept) begin
                    strobe      = w_onehot;
                    input_valid = 1'b1;
                    p_ack       = !r_last_host;
                    h_ack       = r_last_host;
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = 8'(HOLDOFF);
                end else begin
                    p_nack      = !r_last_host;
                    h_nack      = r_last_host;
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (r_cnt <= 8'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_cmd       <= 4'd0;
            r_val       <= 16'd0;
            r_last_host <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_IDLE && (p_req || h_req)) begin
                r_cmd       <= w_grant_host ? h_cmd : p_cmd;
                r_val       <= w_grant_host ? h_val : p_val;
                r_last_host <= w_grant_host;
            end
        end
    end

    assign user_input = r_val;
    assign busy       = (r_state != S_IDLE);
    assign last_host  = r_last_host;

endmodule

// File: tb/tb_panel_cmd_arbiter.sv
// Directed bench for panel_cmd_arbiter: reset, grant latency, round-robin ties,
// reject cases, reset abort and requests queued behind the hold-off window.
module tb_panel_cmd_arbiter;

`ifdef HOST_PRIORITY_EN
    localparam bit HOST_FIRST = 1'b1;
`else
    localparam bit HOST_FIRST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_req, h_req, stopped;
    logic [3:0]  p_cmd, h_cmd;
    logic [15:0] p_val, h_val;
    logic        p_ack, p_nack, h_ack, h_nack;
    logic [11:0] strobe;
    logic [15:0] user_input;
    logic        input_valid, busy, last_host;

    int n_checks = 0;
    int n_pass   = 0;

    panel_cmd_arbiter #(.HOLDOFF(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_cmd(p_cmd), .p_val(p_val), .p_ack(p_ack), .p_nack(p_nack),
        .h_req(h_req), .h_cmd(h_cmd), .h_val(h_val), .h_ack(h_ack), .h_nack(h_nack),
        .stopped(stopped), .strobe(strobe), .user_input(user_input),
        .input_valid(input_valid), .busy(busy), .last_host(last_host)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            tick();
        end
        check(tag, 32'(busy), 0);
    endtask

    int n;
    int hold_n;
    bit ui_stable;
    logic [3:0] bad_codes [4] = '{4'd0, 4'd13, 4'd15, 4'd4};

    initial begin
        rst_n = 1'b0; p_req = 1'b0; h_req = 1'b0; stopped = 1'b0;
        p_cmd = 4'd0; h_cmd = 4'd0; p_val = 16'd0; h_val = 16'd0;
        tick(); tick();
        check("rst_strobe", 32'(strobe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_last_host", 32'(last_host), 1);
        check("rst_user_input", 32'(user_input), 0);
        check("rst_valid_acks", 32'({input_valid, p_ack, p_nack, h_ack, h_nack}), 0);
        rst_n = 1'b1;
        tick();

        // Single panel command: toA with a value, then the hold-off window.
        p_req = 1'b1; p_cmd = 4'h8; p_val = 16'h00A5;
        tick();
        check("t1_strobe", 32'(strobe), 32'h080);
        check("t1_user_input", 32'(user_input), 32'h00A5);
        check("t1_valid", 32'(input_valid), 1);
        check("t1_p_ack", 32'(p_ack), 1);
        check("t1_h_ack", 32'(h_ack), 0);
        check("t1_last_host", 32'(last_host), 0);
        p_req = 1'b0;
        hold_n = 0; ui_stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!busy) break;
            hold_n++;
            if (user_input != 16'h00A5 || strobe != 12'h000) ui_stable = 1'b0;
        end
        check("t1_hold_len", 32'(hold_n), 16);
        check("t1_hold_quiet", 32'(ui_stable), 1);

        // Tie straight out of reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        p_req = 1'b1; p_cmd = 4'd1; p_val = 16'h1111;
        h_req = 1'b1; h_cmd = 4'd1; h_val = 16'h2222;
        tick();
        check("t2_first_p_ack", 32'(p_ack), 32'(!HOST_FIRST));
        check("t2_first_h_ack", 32'(h_ack), 32'(HOST_FIRST));
        check("t2_first_strobe", 32'(strobe), 32'h001);
        check("t2_first_val", 32'(user_input), HOST_FIRST ? 32'h2222 : 32'h1111);
        check("t2_first_last_host", 32'(last_host), 32'(HOST_FIRST));
        if (HOST_FIRST) h_req = 1'b0; else p_req = 1'b0;
        n = 41;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (HOST_FIRST ? p_ack : h_ack) begin n = i; break; end
        end
        check("t2_second_latency", 32'(n), 18);
        check("t2_second_strobe", 32'(strobe), 32'h001);
        check("t2_second_val", 32'(user_input), HOST_FIRST ? 32'h1111 : 32'h2222);
        check("t2_second_last_host", 32'(last_host), 32'(!HOST_FIRST));
        p_req = 1'b0; h_req = 1'b0;
        wait_idle("t2_idle");

        // dec rejected while running, accepted once stopped.
        stopped = 1'b0; h_req = 1'b1; h_cmd = 4'h6; h_val = 16'h0BAD;
        tick();
        check("t3_nack", 32'(h_nack), 1);
        check("t3_nack_ack", 32'(h_ack), 0);
        check("t3_nack_strobe", 32'(strobe), 0);
        check("t3_nack_valid", 32'(input_valid), 0);
        h_req = 1'b0;
        tick();
        check("t3_nack_idle", 32'(busy), 0);
        stopped = 1'b1; h_req = 1'b1;
        tick();
        check("t3_ack_strobe", 32'(strobe), 32'h020);
        check("t3_ack", 32'(h_ack), 1);
        check("t3_ack_nack", 32'(h_nack), 0);
        h_req = 1'b0;
        wait_idle("t3_idle");

        // load is accepted while the CPU runs.
        stopped = 1'b0; p_req = 1'b1; p_cmd = 4'd7; p_val = 16'h0042;
        tick();
        check("t3_load_strobe", 32'(strobe), 32'h040);
        check("t3_load_ack", 32'(p_ack), 1);
        p_req = 1'b0;
        wait_idle("t3_load_idle");

        // Illegal codes and storeinc while running are rejected with no hold-off.
        foreach (bad_codes[k]) begin
            p_req = 1'b1; p_cmd = bad_codes[k];
            tick();
            check($sformatf("t4_nack_%0d", bad_codes[k]), 32'({p_nack, p_ack}), 32'b10);
            check($sformatf("t4_strobe_%0d", bad_codes[k]), 32'(strobe), 0);
            p_req = 1'b0;
            tick();
            check($sformatf("t4_no_hold_%0d", bad_codes[k]), 32'(busy), 0);
        end

        // Reset on the granting edge aborts the command.
        p_req = 1'b1; p_cmd = 4'd2; p_val = 16'hBEEF; rst_n = 1'b0;
        tick();
        check("t5_rst_ack", 32'(p_ack), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_user_input", 32'(user_input), 0);
        rst_n = 1'b1;
        tick();
        check("t5_grant_ack", 32'(p_ack), 1);
        p_req = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("t5_hold_rst_busy", 32'(busy), 0);
        check("t5_hold_rst_ui", 32'(user_input), 0);
        check("t5_hold_rst_last_host", 32'(last_host), 1);
        rst_n = 1'b1;
        tick();

        // Host request raised mid-hold waits for the window to expire.
        p_req = 1'b1; p_cmd = 4'd3; p_val = 16'h0003;
        tick();
        check("t6_panel_strobe", 32'(strobe), 32'h004);
        p_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        h_req = 1'b1; h_cmd = 4'd2; h_val = 16'hCAFE;
        n = 41;
        for (int i = 6; i <= 40; i++) begin
            tick();
            if (h_ack || strobe != 12'h000) begin n = i; break; end
        end
        check("t6_host_latency", 32'(n), 18);
        check("t6_host_strobe", 32'(strobe), 32'h002);
        check("t6_host_val", 32'(user_input), 32'hCAFE);
        h_req = 1'b0;
        wait_idle("t6_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/panel_cmd_arbiter.md
PANEL_CMD_ARBITER -- requirements
Module: panel_cmd_arbiter

Interface
REQ-001 Parameter HOLDOFF, default 16, is the number of guard cycles after each issued command (legal 1..255).
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 p_req / p_cmd / p_val  input  1/4/16  front-panel requester: request, command code, value.
REQ-005 p_ack / p_nack  output  1/1  front-panel completion pulses.
REQ-006 h_req / h_cmd / h_val  input  1/4/16  serial-host requester: request, command code, value.
REQ-007 h_ack / h_nack  output  1/1  host completion pulses.
REQ-008 stopped  input  1  CPU halted status from the CPU control block.
REQ-009 strobe  output  12  one-hot command pulse: bit0 step, 1 reset, 2 runhalt, 3 storeinc, 4 irq, 5 dec, 6 load, 7 toA, 8 toSP, 9 toX, 10 toY, 11 toPC.
REQ-010 user_input / input_valid  output  16/1  value driven to the CPU control block with its qualifier.
REQ-011 busy / last_host  output  1/1  FSM not IDLE; most recent grant went to host.

Function
REQ-012 Command codes 1..12 SHALL map to strobe bits 0..11; codes 0, 13, 14 and 15 SHALL be illegal.
REQ-013 The FSM SHALL have three states: IDLE, ISSUE and HOLD.
REQ-014 In IDLE with any req high, the block SHALL latch the winner's cmd and val at that edge and enter ISSUE.
REQ-015 When both reqs are high, the winner SHALL be the requester not granted last (round-robin); only req=1 sampled in IDLE competes.
REQ-016 ISSUE SHALL last exactly one cycle.
REQ-017 ISSUE rejects the command when the code is illegal, or when it is storeinc/dec with stopped=0 (stopped sampled in ISSUE).
REQ-018 On reject, the block SHALL pulse nack to the winner for one cycle, leave strobe at 0, and return to IDLE.
REQ-019 Otherwise the block SHALL assert the mapped strobe bit, input_valid=1 and the winner's ack, each for exactly that cycle, then enter HOLD.
REQ-020 load while stopped=0 SHALL be accepted.
REQ-021 HOLD SHALL last exactly HOLDOFF cycles, counted by an 8-bit down-counter, and then return to IDLE.
REQ-022 Reqs arriving during ISSUE or HOLD SHALL wait with no preemption, including a reset command.
REQ-023 user_input SHALL equal the latched val from ISSUE until the next ISSUE, and SHALL NOT change during HOLD.
REQ-024 Outputs SHALL decode from registers only, with no combinational path from any req/cmd/val.
REQ-025 Latency: req sampled at edge k leads to strobe/ack/nack in the cycle after edge k.
REQ-026 Requesters SHALL drop req on the edge ending the ack/nack cycle; the arbiter does not re-sample before then.
REQ-027 last_host SHALL update on entry to ISSUE.

Reset
REQ-028 With rst_n=0 at a clk edge, the block SHALL go to state IDLE, holdoff counter 0, strobe 0, all ack/nack 0, input_valid 0, user_input 0, busy 0 and last_host 1, so that the first tie goes to the panel.
REQ-029 Reset asserted during ISSUE or HOLD SHALL abort the command with no ack, nack or strobe after the reset edge.
REQ-030 The block SHALL be reset-insensitive between edges, since reset is synchronous.

Configuration
REQ-031 Macro HOST_PRIORITY_EN defined: the host SHALL win every tie (fixed priority), and last_host SHALL still report the grant.
REQ-032 Macro HOST_PRIORITY_EN undefined: the block SHALL use round-robin per REQ-015.

Verification
REQ-033 p_req=1, p_cmd=4'h8, p_val=16'h00A5: one cycle later strobe=12'h080, user_input=16'h00A5, input_valid=1 and p_ack=1; busy stays high HOLDOFF=16 cycles.
REQ-034 p_req and h_req both high from reset with cmd=1: panel granted first; host strobe 12'h001 after 1+16+1 cycles; with HOST_PRIORITY_EN the host goes first.
REQ-035 h_cmd=4'h6 (dec) with stopped=0: h_nack pulse, strobe stays 0, back in IDLE next cycle; repeat with stopped=1 gives strobe=12'h020 and h_ack.
REQ-036 p_cmd=4'hF: p_nack=1, no strobe, no HOLD.
REQ-037 rst_n=0 asserted on the ISSUE cycle edge: no ack, busy=0 next cycle, user_input=0.
REQ-038 h_req with cmd=2 raised mid-HOLD: strobe=12'h002 exactly one cycle after HOLD expires.
